ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifq_pkg.sv | 19 +
 rtl/ifq_fifo.sv | 48 ++++
 rtl/ifetch_queue.sv | 107 ++++++++++
 tb/tb_ifetch_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared constants and types for the instruction fetch queue.
package ifq_pkg;

  localparam int          IFQ_DEPTH    = 4;
  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IFQ_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFQ_IDLE,
    IFQ_WAIT,
    IFQ_DROP
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Power-of-two circular buffer holding fetched {pc, instr} entries.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch engine: single-outstanding imem requester feeding a queue to IF/ID.
// Define IFQ_BYPASS_EN to present a live response combinationally when the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          stall,
  output logic [31:0]   Instruction_IF,
  output logic [31:0]   PC_Addr_IF,
  output logic          valid_IF,
  output logic [CW-1:0] count
);

  ifq_state_e  state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic        accept, live, byp_hit;
  logic        fifo_push, fifo_pop, fifo_empty;
  ifq_entry_t  head, wr_ent;

  assign imem_req  = (state == IFQ_IDLE) && (count < CW'(DEPTH)) && !redirect && !rst;
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;
  assign live      = (state == IFQ_WAIT) && imem_rvalid && !redirect && !rst;

`ifdef IFQ_BYPASS_EN
  assign byp_hit = live && fifo_empty;
`else
  assign byp_hit = 1'b0;
`endif

  // A bypassed response that is consumed this cycle never touches storage.
  assign fifo_push = live && !(byp_hit && !stall);
  assign fifo_pop  = !fifo_empty && !stall && !redirect && !rst;
  assign wr_ent    = '{pc: req_pc, instr: imem_rdata};
  assign valid_IF  = !fifo_empty || byp_hit;

  always_comb begin
    Instruction_IF = IFQ_NOP;
    PC_Addr_IF     = '0;
    if (!fifo_empty) begin
      Instruction_IF = head.instr;
      PC_Addr_IF     = head.pc;
    end else if (byp_hit) begin
      Instruction_IF = imem_rdata;
      PC_Addr_IF     = req_pc;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH), .W($bits(ifq_entry_t))) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (fifo_push),
    .push_data (wr_ent),
    .pop       (fifo_pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    if (redirect) begin
      fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
      // A response landing in the redirect cycle closes the outstanding request.
      state_nxt    = ((state != IFQ_IDLE) && !imem_rvalid) ? IFQ_DROP : IFQ_IDLE;
    end else begin
      case (state)
        IFQ_IDLE: if (accept) begin
          state_nxt    = IFQ_WAIT;
          req_pc_nxt   = fetch_pc;
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
        IFQ_WAIT, IFQ_DROP: if (imem_rvalid) state_nxt = IFQ_IDLE;
        default: state_nxt = IFQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IFQ_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0, redirect = 1'b0, stall = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic        imem_req, valid_IF;
  logic [31:0] imem_addr, Instruction_IF, PC_Addr_IF;
  logic [2:0]  count;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .Instruction_IF(Instruction_IF), .PC_Addr_IF(PC_Addr_IF), .valid_IF(valid_IF),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model: transaction-level view of outstanding fetch and queued instructions.
  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t        mq[$];
  bit          m_out, m_stale;
  logic [31:0] m_pc, m_req_pc;

  // Bench memory responder.
  bit auto_resp = 0;
  int pend = 0, min_lat = 1, max_lat = 1;

  function automatic bit f_byp();
`ifdef IFQ_BYPASS_EN
    return m_out && !m_stale && imem_rvalid && !redirect && !rst && (mq.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit f_req();
    return !rst && !m_out && (mq.size() < DEPTH) && !redirect;
  endfunction

  function automatic bit f_valid();
    return (mq.size() > 0) || f_byp();
  endfunction

  function automatic logic [31:0] f_pc();
    if (mq.size() > 0) return mq[0].pc;
    if (f_byp()) return m_req_pc;
    return 32'h0;
  endfunction

  function automatic logic [31:0] f_ins();
    if (mq.size() > 0) return mq[0].ins;
    if (f_byp()) return imem_rdata;
    return 32'h0;
  endfunction

  task automatic tick();
    bit acc, byp, pop, push;
    @(posedge clk);
    acc = f_req() && imem_ready;
    if (rst) begin
      mq.delete(); m_out = 0; m_stale = 0; m_pc = RESET_PC;
    end else if (redirect) begin
      mq.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if (m_out && imem_rvalid) m_out = 0;
      m_stale = 1;
    end else begin
      byp  = f_byp();
      pop  = (mq.size() > 0) && !stall;
      push = m_out && !m_stale && imem_rvalid && !(byp && !stall);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{pc: m_req_pc, ins: imem_rdata});
      if (m_out && imem_rvalid) m_out = 0;
      if (acc) begin m_out = 1; m_stale = 0; m_req_pc = m_pc; m_pc = m_pc + 32'd4; end
    end
    #1;
    if (pend > 0) pend--;
    if (acc && !rst && !redirect) pend = $urandom_range(max_lat, min_lat);
    if (auto_resp) begin
      imem_rvalid = (pend == 1);
      imem_rdata  = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1; redirect = 0; stall = 0; imem_rvalid = 0; pend = 0; auto_resp = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; imem_ready = 1; stall = 0; imem_rvalid = 0;
    tick(); tick();
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_vec++; if (valid_IF !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_IF); end
    n_vec++; if (Instruction_IF !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", Instruction_IF); end
    n_vec++; if (PC_Addr_IF !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", PC_Addr_IF); end
    rst = 0;
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b expected 1", imem_req); end
    n_vec++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL first_addr: got %h expected %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    int first = -1, k = 0, want;
    auto_resp = 1; min_lat = 1; max_lat = 1; imem_ready = 1; stall = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (valid_IF && first < 0) first = c;
      if (valid_IF) begin
        n_vec++; if (PC_Addr_IF !== 32'(k * 4)) begin n_err++; $display("FAIL stream_pc: got %h expected %h", PC_Addr_IF, 32'(k * 4)); end
        n_vec++; if (Instruction_IF !== f_ins()) begin n_err++; $display("FAIL stream_instr: got %h expected %h", Instruction_IF, f_ins()); end
        k++;
      end
      tick();
    end
`ifdef IFQ_BYPASS_EN
    want = 1;
`else
    want = 2;
`endif
    n_vec++; if (first != want) begin n_err++; $display("FAIL stream_latency: got %0d expected %0d", first, want); end
  endtask

  task automatic test_stall();
    do_reset();
    auto_resp = 1; min_lat = 1; max_lat = 1; imem_ready = 1; stall = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (valid_IF) begin
        n_vec++; if (PC_Addr_IF !== 32'h0) begin n_err++; $display("FAIL stall_head: got %h expected 0", PC_Addr_IF); end
      end
      tick();
    end
    #1;
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL stall_count: got %0d expected 4", count); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b expected 0", imem_req); end
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (!valid_IF || PC_Addr_IF !== 32'(i * 4)) begin n_err++; $display("FAIL drain_pc: got %h/%b expected %h/1", PC_Addr_IF, valid_IF, 32'(i * 4)); end
      tick();
    end
  endtask

  task automatic test_redirect_drop();
    bit found = 0;
    do_reset();
    auto_resp = 1; min_lat = 2; max_lat = 2; imem_ready = 1; stall = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (m_out && !imem_rvalid) found = 1; else tick();
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL drop_setup: got no outstanding request expected one"); end
    redirect = 1; redirect_pc = 32'h0000_1003;
    tick();
    redirect = 0;
    #1;
    n_vec++; if (valid_IF !== 1'b0) begin n_err++; $display("FAIL drop_valid: got %b expected 0", valid_IF); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL drop_count: got %0d expected 0", count); end
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (imem_req) found = 1; else tick();
    end
    n_vec++; if (!found || imem_addr !== 32'h0000_1000) begin n_err++; $display("FAIL drop_addr: got %h (req %b) expected 00001000", imem_addr, found); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL drop_stale_push: got %0d expected 0", count); end
  endtask

  task automatic test_redirect_rvalid();
    bit found = 0;
    logic [31:0] rpc;
    do_reset();
    auto_resp = 1; min_lat = 1; max_lat = 1; imem_ready = 1; stall = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (imem_rvalid) found = 1; else tick();
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rr_setup: got no response expected one"); end
    rpc = $urandom & 32'hFFFF_FFF0;
    redirect = 1; redirect_pc = rpc;
    tick();
    redirect = 0;
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rr_count: got %0d expected 0", count); end
    n_vec++; if (valid_IF !== 1'b0) begin n_err++; $display("FAIL rr_valid: got %b expected 0", valid_IF); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== rpc) begin n_err++; $display("FAIL rr_refetch: got %b/%h expected 1/%h", imem_req, imem_addr, rpc); end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 0; redirect = 1; redirect_pc = 32'hFFFF_FFFE;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redirect_cycle_req: got %b expected 0", imem_req); end
    tick();
    redirect = 0;
    #1;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_start: got %b/%h expected 1/fffffffc", imem_req, imem_addr); end
    imem_ready = 1; auto_resp = 1; min_lat = 1; max_lat = 1;
    tick();
    imem_ready = 0;
    tick();
    #1;
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h expected 0", imem_addr); end
    n_vec++; if (PC_Addr_IF !== f_pc()) begin n_err++; $display("FAIL wrap_head: got %h expected %h", PC_Addr_IF, f_pc()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_rvalid = 0; imem_ready = 1;
    tick();
    imem_ready = 0; rst = 1;
    tick();
    rst = 0; imem_rvalid = 1; imem_rdata = $urandom;
    #1;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL rstmid_req: got %b/%h expected 1/%h", imem_req, imem_addr, RESET_PC); end
    tick();
    imem_rvalid = 0;
    #1;
    n_vec++; if (count !== 3'd0 || valid_IF !== 1'b0) begin n_err++; $display("FAIL rstmid_push: got count %0d valid %b expected 0/0", count, valid_IF); end
  endtask

  task automatic test_random();
    do_reset();
    auto_resp = 1; min_lat = 1; max_lat = 3;
    for (int c = 0; c < 600; c++) begin
      imem_ready  = ($urandom % 4) != 0;
      stall       = ($urandom % 4) == 0;
      redirect    = ($urandom % 25) == 0;
      redirect_pc = $urandom;
      #1;
      n_vec++; if (imem_req !== f_req()) begin n_err++; $display("FAIL rnd_req @%0d: got %b expected %b", c, imem_req, f_req()); end
      if (f_req()) begin
        n_vec++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr @%0d: got %h expected %h", c, imem_addr, m_pc); end
      end
      n_vec++; if (valid_IF !== f_valid()) begin n_err++; $display("FAIL rnd_valid @%0d: got %b expected %b", c, valid_IF, f_valid()); end
      n_vec++; if (PC_Addr_IF !== f_pc()) begin n_err++; $display("FAIL rnd_pc @%0d: got %h expected %h", c, PC_Addr_IF, f_pc()); end
      n_vec++; if (Instruction_IF !== f_ins()) begin n_err++; $display("FAIL rnd_instr @%0d: got %h expected %h", c, Instruction_IF, f_ins()); end
      n_vec++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count @%0d: got %0d expected %0d", c, count, mq.size()); end
      tick();
    end
    redirect = 0; stall = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_out = 0; m_stale = 0; m_pc = RESET_PC; m_req_pc = RESET_PC;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
